// File: rtl/tdm_demux_pkg.sv
// Shared encodings for the 1x2 TDM demultiplexer: FSM state and slot identifiers.
package tdm_demux_pkg;

   typedef enum logic {
      WAIT_A = 1'b0,
      WAIT_B = 1'b1
   } state_e;

   localparam logic SLOT_A = 1'b0;
   localparam logic SLOT_B = 1'b1;

endpackage

// File: rtl/tdm_demux_1x2_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int W = 4
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         inc,
   output logic [W-1:0] count
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (inc && (count_q != '1)) begin
         count_d = count_q + 1'b1;
      end
   end

   // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/tdm_demux_1x2.sv
// Rebuilds alternating A/B samples from one TDM lane into a registered channel pair,
// with framing-error detection and a saturating error count.
module tdm_demux_1x2
   import tdm_demux_pkg::*;
#(
   parameter int WIDTH = 1,
   parameter int ERR_W = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] m_in,
   input  logic             in_valid,
   input  logic             sync,
   output logic [WIDTH-1:0] A_out,
   output logic [WIDTH-1:0] B_out,
   output logic             pair_valid,
   output logic             select_exp,
   output logic             locked,
   output logic             frame_err,
   output logic [ERR_W-1:0] err_count
);

   state_e           state_q;
   logic [WIDTH-1:0] a_hold_q;
   logic [WIDTH-1:0] a_out_q;
   logic [WIDTH-1:0] b_out_q;
   logic             pair_valid_q;
   logic             frame_err_q;
   logic             locked_q;
   logic             err_inc;

   // A B sample while waiting for A, or a second A while waiting for B, breaks the frame.
   assign err_inc = in_valid && (((state_q == WAIT_A) && !sync) ||
                                 ((state_q == WAIT_B) &&  sync));

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= WAIT_A;
         a_hold_q     <= '0;
         a_out_q      <= '0;
         b_out_q      <= '0;
         pair_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
         locked_q     <= 1'b0;
      end else begin
         pair_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
         if (in_valid) begin
            case (state_q)
               WAIT_A: begin
                  if (sync) begin
                     a_hold_q <= m_in;
                     state_q  <= WAIT_B;
                  end else begin
                     frame_err_q <= 1'b1;
                     locked_q    <= 1'b0;
                  end
               end
               WAIT_B: begin
                  if (!sync) begin
                     a_out_q      <= a_hold_q;
                     b_out_q      <= m_in;
                     pair_valid_q <= 1'b1;
                     locked_q     <= 1'b1;
                     state_q      <= WAIT_A;
                  end else begin
                     // Repeated A restarts the frame around the newest A sample.
                     a_hold_q    <= m_in;
                     frame_err_q <= 1'b1;
                     locked_q    <= 1'b0;
                  end
               end
               default: state_q <= WAIT_A;
            endcase
         end
      end
   end

   sat_counter #(
      .W (ERR_W)
   ) u_err_cnt (
      .clock (clock),
      .reset (reset),
      .inc   (err_inc),
      .count (err_count)
   );

   assign select_exp = (state_q == WAIT_B) ? SLOT_B : SLOT_A;
   assign A_out      = a_out_q;
   assign B_out      = b_out_q;
   assign pair_valid = pair_valid_q;
   assign frame_err  = frame_err_q;
   assign locked     = locked_q;

endmodule

// File: tb/tb_tdm_demux_1x2.sv
// Directed bench for tdm_demux_1x2 with WIDTH=8, ERR_W=4 and hand-computed expectations.
module tb_tdm_demux_1x2;

   logic       clock;
   logic       reset;
   logic [7:0] m_in;
   logic       in_valid;
   logic       sync;
   logic [7:0] A_out;
   logic [7:0] B_out;
   logic       pair_valid;
   logic       select_exp;
   logic       locked;
   logic       frame_err;
   logic [3:0] err_count;

   int n_checks = 0;
   int n_pass   = 0;

   tdm_demux_1x2 #(
      .WIDTH (8),
      .ERR_W (4)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .m_in       (m_in),
      .in_valid   (in_valid),
      .sync       (sync),
      .A_out      (A_out),
      .B_out      (B_out),
      .pair_valid (pair_valid),
      .select_exp (select_exp),
      .locked     (locked),
      .frame_err  (frame_err),
      .err_count  (err_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Apply one input vector, let one rising edge consume it, return 1 time unit after that edge.
   task automatic drive(input logic v, input logic s, input logic [7:0] d);
      in_valid = v;
      sync     = s;
      m_in     = d;
      @(posedge clock);
      #1;
   endtask

   task automatic check_all(input string tag, input logic [7:0] a, input logic [7:0] b,
                            input logic pv, input logic sel, input logic lk,
                            input logic fe, input logic [3:0] ec);
      check({tag, ".A_out"},      A_out,      a);
      check({tag, ".B_out"},      B_out,      b);
      check({tag, ".pair_valid"}, pair_valid, pv);
      check({tag, ".select_exp"}, select_exp, sel);
      check({tag, ".locked"},     locked,     lk);
      check({tag, ".frame_err"},  frame_err,  fe);
      check({tag, ".err_count"},  err_count,  ec);
   endtask

   initial begin
      reset    = 1'b1;
      in_valid = 1'b0;
      sync     = 1'b0;
      m_in     = 8'h00;
      repeat (2) @(posedge clock);
      #1;
      check_all("rst", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
      reset = 1'b0;

      // 1: single pair
      drive(1'b1, 1'b1, 8'h3C);
      check_all("s1.a", 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
      drive(1'b1, 1'b0, 8'hA5);
      check_all("s1.b", 8'h3C, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0);
      drive(1'b0, 1'b0, 8'h00);
      check_all("s1.idle", 8'h3C, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0);

      // 2: back-to-back frames
      drive(1'b1, 1'b1, 8'h11);
      check_all("s2.a0", 8'h3C, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0);
      drive(1'b1, 1'b0, 8'h22);
      check_all("s2.b0", 8'h11, 8'h22, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0);
      drive(1'b1, 1'b1, 8'h33);
      check_all("s2.a1", 8'h11, 8'h22, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0);
      drive(1'b1, 1'b0, 8'h44);
      check_all("s2.b1", 8'h33, 8'h44, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0);
      drive(1'b0, 1'b0, 8'h00);
      check_all("s2.idle", 8'h33, 8'h44, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0);

      // 3: gap between A and B; garbage on m_in/sync while idle is ignored
      drive(1'b1, 1'b1, 8'h10);
      check_all("s3.a", 8'h33, 8'h44, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0);
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, i[0], 8'hE0 + 8'(i));
         check_all("s3.gap", 8'h33, 8'h44, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0);
      end
      drive(1'b1, 1'b0, 8'h20);
      check_all("s3.b", 8'h10, 8'h20, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0);
      drive(1'b0, 1'b0, 8'h00);

      // 4: framing faults
      drive(1'b1, 1'b0, 8'h77);
      check_all("s4.bnoa", 8'h10, 8'h20, 1'b0, 1'b0, 1'b0, 1'b1, 4'h1);
      drive(1'b0, 1'b0, 8'h00);
      check_all("s4.idle", 8'h10, 8'h20, 1'b0, 1'b0, 1'b0, 1'b0, 4'h1);
      drive(1'b1, 1'b1, 8'h01);
      check_all("s4.a1", 8'h10, 8'h20, 1'b0, 1'b1, 1'b0, 1'b0, 4'h1);
      drive(1'b1, 1'b1, 8'h02);
      check_all("s4.a2", 8'h10, 8'h20, 1'b0, 1'b1, 1'b0, 1'b1, 4'h2);
      drive(1'b1, 1'b0, 8'h03);
      check_all("s4.b", 8'h02, 8'h03, 1'b1, 1'b0, 1'b1, 1'b0, 4'h2);

      // 5: saturation over 18 stray B samples
      for (int i = 0; i < 18; i++) begin
         drive(1'b1, 1'b0, 8'h90 + 8'(i));
         check_all("s5.sat", 8'h02, 8'h03, 1'b0, 1'b0, 1'b0, 1'b1,
                   (i + 3 > 15) ? 4'hF : 4'(i + 3));
      end
      drive(1'b0, 1'b0, 8'h00);
      check_all("s5.end", 8'h02, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0, 4'hF);

      // 6: asynchronous reset mid-frame
      drive(1'b1, 1'b1, 8'h55);
      check("s6.sel_before", select_exp, 1'b1);
      in_valid = 1'b0;
      #2 reset = 1'b1;
      #1;
      check_all("s6.rst", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
      #2 reset = 1'b0;
      drive(1'b1, 1'b0, 8'h66);
      check_all("s6.b", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 4'h1);
      drive(1'b0, 1'b0, 8'h00);
      check_all("s6.idle", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 4'h1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/tdm_demux_1x2.md
Name: tdm_demux_1x2

Overview:
Receive-side counterpart of the 2x1 multiplexer. It takes a time-multiplexed stream in which the A and B samples alternate on one lane, and a sync flag that marks each A slot. It rebuilds the two channels into registered, simultaneously updated outputs. It also reports framing errors and the slot it expects next, so a bench can drive a mux-based transmitter against it.

Parameters:
WIDTH, 1, bit width of each channel sample and of m_in
ERR_W, 4, width of the saturating framing-error counter

Ports:
clock  input  1  single system clock, rising-edge active
reset  input  1  asynchronous, active-high reset
m_in  input  WIDTH  multiplexed sample lane
in_valid  input  1  m_in carries a sample this cycle
sync  input  1  qualified by in_valid; 1 = this sample is slot A
A_out  output  WIDTH  last complete channel-A sample
B_out  output  WIDTH  last complete channel-B sample
pair_valid  output  1  one-cycle pulse: A_out/B_out just updated
select_exp  output  1  slot expected next: 0 = A, 1 = B (mirrors the mux select)
locked  output  1  at least one good pair received since the last error or reset
frame_err  output  1  one-cycle pulse on a framing violation
err_count  output  ERR_W  saturating count of framing violations

Behaviour:
- Reset (asynchronous, active-high): state WAIT_A; A_out=0, B_out=0, a_hold=0, pair_valid=0, frame_err=0, locked=0, err_count=0.
- Reset asserted mid-frame discards any held A sample; no pair_valid follows.
- Cycles with in_valid=0 change nothing except clearing the pulses. sync and m_in are ignored. There is no timeout.
- State WAIT_A (select_exp=0):
  - in_valid&&sync: a_hold<=m_in, go to WAIT_B.
  - in_valid&&!sync: a B sample with no A. Pulse frame_err, increment err_count, clear locked, stay in WAIT_A, discard the sample.
- State WAIT_B (select_exp=1):
  - in_valid&&!sync: A_out<=a_hold and B_out<=m_in on the same edge. pair_valid=1 for exactly the next cycle, locked<=1, go to WAIT_A.
  - in_valid&&sync: a repeated A. Pulse frame_err, increment err_count, clear locked. a_hold<=m_in, which restarts the frame with the new A. Stay in WAIT_B.
- select_exp is decoded combinationally from the state register.
- All other outputs are registered.
- Latency: A_out, B_out and pair_valid are visible one clock after the B sample edge.
- A_out and B_out hold their values between pairs and never update singly.
- err_count saturates at 2^ERR_W-1 and never wraps. frame_err still pulses at saturation.
- Back-to-back frames (A,B,A,B with in_valid held high) produce pair_valid every second cycle, with no bubbles required.
- pair_valid and frame_err are never asserted together.

Decomposition:
- Package tdm_demux_pkg:
  - state encoding constants WAIT_A=1'b0, WAIT_B=1'b1.
  - slot constants SLOT_A=1'b0, SLOT_B=1'b1.
- One sub-module: sat_counter (parameter W, with clock, reset, inc and count ports).
  - Asynchronous active-high reset to 0; saturates at all-ones.
  - Used for err_count.
- Everything else stays in tdm_demux_1x2.

Test Plan:
All scenarios use WIDTH=8, ERR_W=4.
1. Reset, then valid (sync=1, m_in=8'h3C) then (sync=0, m_in=8'hA5) -> one cycle later A_out=8'h3C, B_out=8'hA5, pair_valid=1 for one cycle, locked=1, select_exp sequence 0,1,0.
2. Four back-to-back samples 11(A),22(B),33(A),44(B) -> pair_valid pulses twice, 2 cycles apart; final A_out=8'h33, B_out=8'h44; frame_err never asserted.
3. A=8'h10, idle 5 cycles (in_valid=0), then B=8'h20 -> select_exp=1 throughout the gap; a single pair (10,20) is produced; the outputs keep their previous values until then.
4. Framing faults:
   - B sample in WAIT_A -> frame_err pulse, err_count=1, state unchanged.
   - Then A=8'h01 and A=8'h02 -> second frame_err, err_count=2, locked=0.
   - Then B=8'h03 -> pair (02,03).
5. Eighteen consecutive B-only samples -> err_count reaches 4'hF and stays; frame_err pulses on all 18; A_out/B_out unchanged.
6. Assert reset asynchronously (between clock edges) after A=8'h55, then release and send B=8'h66 -> all outputs 0 immediately on reset; no pair_valid; B counted as a frame error (err_count=1).
